// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and types for the instruction-SRAM responder.
// INST_BASE is the reset PC (word 0 of the array); INST_NOP is the LoongArch nop.
package inst_sram_responder_pkg;

    localparam logic [31:0] INST_BASE = 32'h1c000000;
    localparam logic [31:0] INST_NOP  = 32'h03400000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/inst_sram_responder_sram.sv
// Behavioural single-port word array with a registered read and per-byte write enables.
// A read and a write to the same word in one cycle return the old word.
// rdata holds whenever rd_en is low, so write-only traffic never disturbs it.
module sram_1rw_bytewe #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Capture the addressed word and merge in any enabled byte lanes.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// Responder end of the fetch-stage instruction-SRAM port.
// After reset the array is zeroed one word per cycle (CLEAR), then requests are served (READY).
// Port priority is clear > core > preload; the core always wins over the load port.
// Out-of-range or not-yet-ready requests return the nop and never write.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = INST_BASE,
    parameter int          DEPTH_LOG2     = 12,
    parameter logic [31:0] NOP_INST       = INST_NOP,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_sram_en,
    input  logic [3:0]            inst_sram_we,
    input  logic [31:0]           inst_sram_addr,
    input  logic [31:0]           inst_sram_wdata,
    output logic [31:0]           inst_sram_rdata,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  init_busy,
    output logic                  addr_err,
    input  logic                  addr_err_clr
);

    localparam logic [32:0]           SPAN    = 33'd4 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE = 1;

    state_t                  state;
    state_t                  state_next;
    logic [DEPTH_LOG2-1:0]   cnt;
    logic [31:0]             off;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    nop_sel;

    logic                    mem_rd_en;
    logic [3:0]              mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rdata;

    // Modular subtraction lets addresses below the base wrap to huge offsets and fail the range check.
    assign off       = inst_sram_addr - ADDR_BASE;
    assign in_range  = {1'b0, off} < SPAN;
    assign idx       = off[DEPTH_LOG2+1:2];
    assign init_busy = (state == ST_CLEAR);

    // State register and clear counter; a reset mid-clear restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Next state and the single-port mux: clear sweep, then core, then preload.
    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        mem_we     = 4'h0;
        mem_addr   = '0;
        mem_wdata  = '0;
        load_ready = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we   = 4'hf;
                mem_addr = cnt;
                if (&cnt) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                load_ready = ~inst_sram_en;
                if (inst_sram_en) begin
                    if (in_range) begin
                        mem_rd_en = 1'b1;
                        mem_we    = inst_sram_we;
                        mem_addr  = idx;
                        mem_wdata = inst_sram_wdata;
                    end
                end else if (load_valid) begin
                    mem_we    = 4'hf;
                    mem_addr  = load_addr;
                    mem_wdata = load_data;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // Remember whether the last core request should see the nop; idle cycles keep the old choice.
    always_ff @(posedge clk) begin
        if (reset) begin
            nop_sel <= 1'b1;
        end else if (inst_sram_en) begin
            nop_sel <= !((state == ST_READY) && in_range);
        end
    end

    // Sticky range error; a new error in the same cycle beats the clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (inst_sram_en && !in_range) begin
            addr_err <= 1'b1;
        end else if (addr_err_clr) begin
            addr_err <= 1'b0;
        end
    end

    sram_1rw_bytewe #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk  (clk),
        .rd_en(mem_rd_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    assign inst_sram_rdata = nop_sel ? NOP_INST : mem_rdata;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder with a 16-word array.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_inst_sram_responder;

    localparam int          DEPTH_LOG2 = 4;
    localparam logic [31:0] BASE       = 32'h1c000000;
    localparam logic [31:0] NOP        = 32'h03400000;

    logic                  clk;
    logic                  reset;
    logic                  inst_sram_en;
    logic [3:0]            inst_sram_we;
    logic [31:0]           inst_sram_addr;
    logic [31:0]           inst_sram_wdata;
    logic [31:0]           inst_sram_rdata;
    logic                  load_valid;
    logic                  load_ready;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [31:0]           load_data;
    logic                  init_busy;
    logic                  addr_err;
    logic                  addr_err_clr;

    int checks = 0;
    int errors = 0;
    int busy_cycles;

    inst_sram_responder #(
        .ADDR_BASE     (BASE),
        .DEPTH_LOG2    (DEPTH_LOG2),
        .NOP_INST      (NOP),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .init_busy      (init_busy),
        .addr_err       (addr_err),
        .addr_err_clr   (addr_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one core request (or an idle cycle with en=0) and advance one clock.
    task automatic applyStimulus(input logic en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        tick();
    endtask

    // Count cycles until init_busy drops, bounded so a stuck clear still ends the run.
    task automatic countBusy(output int n);
        n = 0;
        while (init_busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset           = 1'b1;
        inst_sram_en    = 1'b0;
        inst_sram_we    = 4'h0;
        inst_sram_addr  = BASE;
        inst_sram_wdata = 32'h0;
        load_valid      = 1'b0;
        load_addr       = '0;
        load_data       = 32'h0;
        addr_err_clr    = 1'b0;

        // Reset state and clear sweep length
        tick();
        tick();
        checkOutput("rst_rdata", inst_sram_rdata, NOP);
        checkOutput("rst_busy", 32'(init_busy), 32'd1);
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        reset = 1'b0;
        countBusy(busy_cycles);
        checkOutput("clear_cycles", 32'(busy_cycles), 32'd16);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("clear_rd0", inst_sram_rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, BASE + 32'h3c, 32'h0);
        checkOutput("clear_rd15", inst_sram_rdata, 32'h0);

        // Preload word 0, read it back, then hold rdata through idle cycles
        inst_sram_en = 1'b0;
        load_valid   = 1'b1;
        load_addr    = 4'd0;
        load_data    = 32'h02800c0c;
        #1;
        checkOutput("pre_load_ready", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        checkOutput("load_keeps_rdata", inst_sram_rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("rd_preload", inst_sram_rdata, 32'h02800c0c);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'h0, BASE + 32'h4, 32'h0);
            checkOutput("hold", inst_sram_rdata, 32'h02800c0c);
        end

        // Byte-lane write: lanes 0 and 2 take AABBCCDD's bytes DD and BB over 11223344
        applyStimulus(1'b1, 4'hf, BASE + 32'h8, 32'h11223344);
        checkOutput("wr_full_old", inst_sram_rdata, 32'h0);
        applyStimulus(1'b1, 4'b0101, BASE + 32'h8, 32'hAABBCCDD);
        checkOutput("wr_byte_old", inst_sram_rdata, 32'h11223344);
        applyStimulus(1'b1, 4'h0, BASE + 32'h8, 32'h0);
        checkOutput("rd_merged", inst_sram_rdata, 32'h11BB33DD);

        // Address range boundaries and sticky error
        checkOutput("err_before", 32'(addr_err), 32'd0);
        applyStimulus(1'b1, 4'hf, 32'h1bfffffc, 32'hFFFFFFFF);
        checkOutput("below_rdata", inst_sram_rdata, NOP);
        checkOutput("below_err", 32'(addr_err), 32'd1);
        applyStimulus(1'b1, 4'h0, BASE + 32'h40, 32'h0);
        checkOutput("above_rdata", inst_sram_rdata, NOP);
        applyStimulus(1'b1, 4'h0, BASE + 32'h3c, 32'h0);
        checkOutput("last_word_rdata", inst_sram_rdata, 32'h0);
        checkOutput("err_sticky", 32'(addr_err), 32'd1);
        addr_err_clr = 1'b1;
        applyStimulus(1'b0, 4'h0, BASE, 32'h0);
        checkOutput("err_cleared", 32'(addr_err), 32'd0);
        applyStimulus(1'b1, 4'h0, 32'h1bfffffc, 32'h0);
        checkOutput("err_set_beats_clr", 32'(addr_err), 32'd1);
        addr_err_clr = 1'b0;

        // Load port blocked while the core is active
        load_valid = 1'b1;
        load_addr  = 4'd6;
        load_data  = 32'h11111111;
        inst_sram_en = 1'b1;
        #1;
        checkOutput("load_blocked", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        checkOutput("rd_during_load", inst_sram_rdata, 32'h0);
        load_addr = 4'd5;
        load_data = 32'hDEADBEEF;
        inst_sram_en = 1'b0;
        #1;
        checkOutput("load_open", 32'(load_ready), 32'd1);
        applyStimulus(1'b0, 4'h0, BASE + 32'h14, 32'h0);
        load_valid = 1'b0;
        applyStimulus(1'b1, 4'h0, BASE + 32'h18, 32'h0);
        checkOutput("blocked_not_written", inst_sram_rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        checkOutput("ready_written", inst_sram_rdata, 32'hDEADBEEF);

        // Reset mid-clear restarts the full sweep; requests during clear get the nop
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0, BASE, 32'h0);
        reset = 1'b0;
        checkOutput("rst2_err", 32'(addr_err), 32'd0);
        load_valid = 1'b1;
        load_addr  = 4'd7;
        load_data  = 32'h12345678;
        applyStimulus(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        checkOutput("clear_rd_nop", inst_sram_rdata, NOP);
        checkOutput("clear_load_ready", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 4'h0, BASE + 32'h80, 32'h0);
        checkOutput("clear_range_err", 32'(addr_err), 32'd1);
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'h0, BASE, 32'h0);
        end
        checkOutput("mid_clear_busy", 32'(init_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        countBusy(busy_cycles);
        checkOutput("restart_cycles", 32'(busy_cycles), 32'd16);
        applyStimulus(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        checkOutput("recleared_rd5", inst_sram_rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("recleared_rd0", inst_sram_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
